// File: rtl/adc_responder_emu_if.sv
// -----------------------------------------------------------------------------
// adc_responder_emu_if
//   Parallel ADC conversion/readout bus between the acquisition driver (master)
//   and the ADC, or its on-FPGA emulation (slave).
//   convst_a..d : conversion start; the ADC acts only when all four are high
//   cs_n, rd_n  : chip select / read strobe, both active low
//   busy        : conversion in progress
//   db, db_oe   : data word and enable for the tri-state buffer in the top wrapper
// -----------------------------------------------------------------------------
interface adc_responder_emu_if;
  logic        convst_a;
  logic        convst_b;
  logic        convst_c;
  logic        convst_d;
  logic        cs_n;
  logic        rd_n;
  logic        busy;
  logic [15:0] db;
  logic        db_oe;

  modport master (
    output convst_a, convst_b, convst_c, convst_d, cs_n, rd_n,
    input  busy, db, db_oe
  );

  modport slave (
    input  convst_a, convst_b, convst_c, convst_d, cs_n, rd_n,
    output busy, db, db_oe
  );
endinterface

// File: rtl/adc_responder_emu.sv
// -----------------------------------------------------------------------------
// adc_responder_emu
//   Synthesizable stand-in for the 8-channel parallel ADC. It answers a CONVST
//   with a Busy pulse of CONV_CYCLES clocks, then serves one 16-bit word per
//   RD_N strobe. The data are per-channel ramps (channel i starts at
//   i*CH_OFFSET and advances by RAMP_STEP every conversion), so the downstream
//   ADC->FIFO->SPI chain can run without real hardware. An inject pulse
//   replaces channel 0 of the next conversion with a chosen value.
//
// Ports
//   i_clk          system clock (shared with the driver)
//   i_rst_n        asynchronous reset, active low
//   i_adc_rst      synchronous soft reset of the emulated ADC, active high
//   i_stby_n       0 = standby, new conversion starts are ignored
//   i_inject_en    1-cycle pulse: replace ch0 of the next conversion
//   i_inject_val   value used for that replacement
//   sif            ADC bus (slave side): convst_a..d, cs_n, rd_n in;
//                  busy, db, db_oe out
//   o_overrun      sticky: CONVST arrived while converting or during readout
//   o_conv_count   completed conversions, wraps at 2^16
// -----------------------------------------------------------------------------

// Per-channel ramp generator and conversion result holder.
module adc_responder_emu_ch #(
  parameter int          CH        = 0,
  parameter logic [15:0] RAMP_STEP = 16'd1,
  parameter logic [15:0] CH_OFFSET = 16'd256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_soft_rst,
  input  logic        i_start,     // conversion start: capture ramp, advance it
  input  logic        i_inj,       // use i_inj_val instead of the ramp this time
  input  logic [15:0] i_inj_val,
  output logic [15:0] o_res
);
  // Reset value of the ramp, taken mod 2^16.
  localparam logic [15:0] RAMP_RST = 16'(CH * int'(CH_OFFSET));

  logic [15:0] r_ramp;
  logic [15:0] r_res;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ramp <= RAMP_RST;
      r_res  <= '0;
    end else if (i_soft_rst) begin
      r_ramp <= RAMP_RST;
      r_res  <= '0;
    end else if (i_start) begin
      r_res  <= i_inj ? i_inj_val : r_ramp;
      // The ramp advances even when the sample was replaced by an injection,
      // so the channel resumes its normal sequence afterwards.
      r_ramp <= r_ramp + RAMP_STEP;
    end
  end

  assign o_res = r_res;
endmodule

module adc_responder_emu #(
  parameter int          NUM_CHANNELS = 8,
  parameter int          CONV_CYCLES  = 20,
  parameter logic [15:0] RAMP_STEP    = 16'd1,
  parameter logic [15:0] CH_OFFSET    = 16'd256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_adc_rst,
  input  logic                     i_stby_n,
  input  logic                     i_inject_en,
  input  logic [15:0]              i_inject_val,
  adc_responder_emu_if.slave       sif,
  output logic                     o_overrun,
  output logic [15:0]              o_conv_count
);
  localparam int IDXW = $clog2(NUM_CHANNELS + 1);
  localparam int SELW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNTW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // One register stage on the bus inputs, plus the previous sample for edges.
  logic r_cv, r_cv_d;
  logic r_rd, r_rd_d;
  logic w_cv_rise, w_rd_rise;

  logic [CNTW-1:0]                    r_cnt;
  logic [IDXW-1:0]                    r_idx;
  logic [SELW-1:0]                    w_sel;
  logic                               w_idx_lt;
  logic [15:0]                        r_db;
  logic                               r_db_oe;
  logic                               r_overrun;
  logic [15:0]                        r_conv_count;
  logic                               r_inj_pend;
  logic [15:0]                        r_inj_val;
  logic [NUM_CHANNELS-1:0][15:0]      w_res;

  // FSM decode strobes.
  logic w_start;    // begin a conversion (capture ramps)
  logic w_done;     // conversion time elapsed
  logic w_ovr;      // set sticky overrun
  logic w_db_ld;    // serve res[idx]
  logic w_db_zero;  // strobe with nothing left to serve

  assign w_cv_rise = r_cv & ~r_cv_d;
  assign w_rd_rise = r_rd & ~r_rd_d;
  assign w_idx_lt  = (r_idx < IDXW'(NUM_CHANNELS));
  assign w_sel     = r_idx[SELW-1:0];

  // ---------------------------------------------------------------------------
  // Per-channel ramps
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    adc_responder_emu_ch #(
      .CH        (g),
      .RAMP_STEP (RAMP_STEP),
      .CH_OFFSET (CH_OFFSET)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_soft_rst (i_adc_rst),
      .i_start    (w_start),
      .i_inj      ((g == 0) ? r_inj_pend : 1'b0),
      .i_inj_val  (r_inj_val),
      .o_res      (w_res[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cv   <= 1'b0;
      r_cv_d <= 1'b0;
      r_rd   <= 1'b0;
      r_rd_d <= 1'b0;
    end else if (i_adc_rst) begin
      r_cv   <= 1'b0;
      r_cv_d <= 1'b0;
      r_rd   <= 1'b0;
      r_rd_d <= 1'b0;
    end else begin
      r_cv   <= sif.convst_a & sif.convst_b & sif.convst_c & sif.convst_d;
      r_cv_d <= r_cv;
      // CS_N high masks the read strobe entirely.
      r_rd   <= ~sif.rd_n & ~sif.cs_n;
      r_rd_d <= r_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_state <= S_IDLE;
    else if (i_adc_rst) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_ovr       = 1'b0;
    w_db_ld     = 1'b0;
    w_db_zero   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cv_rise && i_stby_n) begin
          w_start     = 1'b1;
          w_state_nxt = S_CONVERT;
        end else if (w_rd_rise) begin
          w_db_zero = 1'b1;
        end
      end
      S_CONVERT: begin
        // A start request here is dropped but remembered as an overrun.
        // Standby does not cut a running conversion short.
        if (w_cv_rise) w_ovr = 1'b1;
        if (w_rd_rise) w_db_zero = 1'b1;
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_READOUT;
        end
      end
      S_READOUT: begin
        if (w_cv_rise) begin
          // New start abandons the readout; it wins over a coincident read.
          w_ovr = 1'b1;
          if (i_stby_n) begin
            w_start     = 1'b1;
            w_state_nxt = S_CONVERT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_rd_rise) begin
          if (w_idx_lt) w_db_ld   = 1'b1;
          else          w_db_zero = 1'b1;
        end else if (!w_idx_lt && !r_rd) begin
          // All words served and the last strobe released.
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_db         <= '0;
      r_db_oe      <= 1'b0;
      r_overrun    <= 1'b0;
      r_conv_count <= '0;
      r_inj_pend   <= 1'b0;
      r_inj_val    <= '0;
    end else if (i_adc_rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_db         <= '0;
      r_db_oe      <= 1'b0;
      r_overrun    <= 1'b0;
      r_conv_count <= '0;
      r_inj_pend   <= 1'b0;
      r_inj_val    <= '0;
    end else begin
      // Busy lasts CONV_CYCLES cycles: loaded with N-1, exits on zero.
      if (w_start)
        r_cnt <= CNTW'(CONV_CYCLES - 1);
      else if (r_state == S_CONVERT && r_cnt != '0)
        r_cnt <= r_cnt - CNTW'(1);

      if (w_done) begin
        r_conv_count <= r_conv_count + 16'd1;
        r_idx        <= '0;
      end else if (w_db_ld) begin
        r_idx <= r_idx + IDXW'(1);
      end

      if (w_db_ld)        r_db <= w_res[w_sel];
      else if (w_db_zero) r_db <= '0;

      // Enable follows the sampled strobe, aligned with the DB update.
      r_db_oe <= r_rd;

      if (w_ovr) r_overrun <= 1'b1;

      // The start consumes a pending injection; a pulse in the same cycle
      // arms the next conversion instead.
      if (i_inject_en) begin
        r_inj_pend <= 1'b1;
        r_inj_val  <= i_inject_val;
      end else if (w_start) begin
        r_inj_pend <= 1'b0;
      end
    end
  end

  assign sif.busy     = (r_state == S_CONVERT);
  assign sif.db       = r_db;
  assign sif.db_oe    = r_db_oe;
  assign o_overrun    = r_overrun;
  assign o_conv_count = r_conv_count;
endmodule

// File: tb/tb_adc_responder_emu.sv
module tb_adc_responder_emu;
  logic        i_clk;
  logic        i_rst_n;
  logic        i_adc_rst;
  logic        i_stby_n;
  logic        i_inject_en;
  logic [15:0] i_inject_val;
  logic        o_overrun;
  logic [15:0] o_conv_count;

  adc_responder_emu_if bif();

  adc_responder_emu dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_adc_rst    (i_adc_rst),
    .i_stby_n     (i_stby_n),
    .i_inject_en  (i_inject_en),
    .i_inject_val (i_inject_val),
    .sif          (bif),
    .o_overrun    (o_overrun),
    .o_conv_count (o_conv_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        inj;
    logic [15:0] inj_val;
    logic [15:0] exp_ch0;
    logic [15:0] k;        // ramp offset: ch i (i>0) expected i*256 + k
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic convst_all(input logic v);
    bif.convst_a = v;
    bif.convst_b = v;
    bif.convst_c = v;
    bif.convst_d = v;
  endtask

  // Pulse CONVST, then measure how many cycles Busy stays high (bounded).
  // pulse_at >= 0 raises CONVST again during that loop cycle.
  task automatic conv_meas(input int pulse_at, output int len);
    logic b;
    len = 0;
    convst_all(1'b1);
    tick(1);
    convst_all(1'b0);
    for (int i = 0; i < 60; i++) begin
      convst_all(i == pulse_at);
      @(negedge i_clk);
      b = bif.busy;
      @(posedge i_clk);
      #1;
      if (b) len++;
      else if (len > 0) break;
    end
    convst_all(1'b0);
  endtask

  task automatic rd_word(output logic [15:0] d, output logic oe);
    bif.rd_n = 1'b0;
    tick(3);
    @(negedge i_clk);
    d  = bif.db;
    oe = bif.db_oe;
    @(posedge i_clk);
    #1;
    bif.rd_n = 1'b1;
    tick(2);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] exp);
    logic [15:0] d;
    logic        oe;
    rd_word(d, oe);
    chk({nm, "_db"}, d, exp);
    chk({nm, "_oe"}, oe, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          len;
    logic [15:0] exp;
    logic [15:0] d;
    logic        oe;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 16'd0};
    vecs[1] = '{1'b0, 16'h0000, 16'h0001, 16'd1};
    vecs[2] = '{1'b0, 16'h0000, 16'h0002, 16'd2};
    vecs[3] = '{1'b1, 16'h7FFF, 16'h7FFF, 16'd3};
    vecs[4] = '{1'b0, 16'h0000, 16'h0004, 16'd4};

    i_rst_n      = 1'b0;
    i_adc_rst    = 1'b0;
    i_stby_n     = 1'b1;
    i_inject_en  = 1'b0;
    i_inject_val = 16'h0;
    convst_all(1'b0);
    bif.cs_n = 1'b1;
    bif.rd_n = 1'b1;
    tick(3);
    chk("rst_busy", bif.busy, 1'b0);
    chk("rst_db", bif.db, 16'h0);
    chk("rst_db_oe", bif.db_oe, 1'b0);
    chk("rst_overrun", o_overrun, 1'b0);
    chk("rst_count", o_conv_count, 16'h0);
    i_rst_n = 1'b1;
    bif.cs_n = 1'b0;
    tick(2);

    // Table: conversions with ramp data and one injection.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].inj) begin
        i_inject_val = vecs[v].inj_val;
        i_inject_en  = 1'b1;
        tick(1);
        i_inject_en  = 1'b0;
        tick(1);
      end
      conv_meas(-1, len);
      chk($sformatf("v%0d_busy_len", v), len, 20);
      chk($sformatf("v%0d_count", v), o_conv_count, v + 1);
      for (int c = 0; c < 8; c++) begin
        exp = (c == 0) ? vecs[v].exp_ch0 : (16'(c * 256) + vecs[v].k);
        rd_chk($sformatf("v%0d_ch%0d", v, c), exp);
      end
      chk($sformatf("v%0d_overrun", v), o_overrun, 1'b0);
    end

    // Read beyond the last channel: zero word, enable still follows strobe.
    rd_chk("extra_read", 16'h0000);

    // CONVST during Busy: length unchanged, overrun set.
    conv_meas(5, len);
    chk("ovr_busy_len", len, 20);
    chk("ovr_busy_flag", o_overrun, 1'b1);
    chk("ovr_busy_count", o_conv_count, 16'd6);
    rd_chk("c6_ch0", 16'd5);
    rd_chk("c6_ch1", 16'd261);
    rd_chk("c6_ch2", 16'd517);

    // Soft reset mid-readout.
    i_adc_rst = 1'b1;
    tick(1);
    i_adc_rst = 1'b0;
    tick(1);
    chk("srst_count", o_conv_count, 16'h0);
    chk("srst_overrun", o_overrun, 1'b0);
    chk("srst_db", bif.db, 16'h0);
    chk("srst_busy", bif.busy, 1'b0);

    // CONVST after three reads: readout abandoned, new conversion.
    conv_meas(-1, len);
    chk("a_count", o_conv_count, 16'd1);
    rd_chk("a_ch0", 16'd0);
    rd_chk("a_ch1", 16'd256);
    rd_chk("a_ch2", 16'd512);
    chk("a_overrun", o_overrun, 1'b0);
    conv_meas(-1, len);
    chk("rdovr_busy_len", len, 20);
    chk("rdovr_flag", o_overrun, 1'b1);
    chk("rdovr_count", o_conv_count, 16'd2);
    for (int c = 0; c < 8; c++)
      rd_chk($sformatf("b_ch%0d", c), 16'(c * 256) + 16'd1);

    // Standby: CONVST ignored.
    i_stby_n = 1'b0;
    conv_meas(-1, len);
    chk("stby_busy_len", len, 0);
    chk("stby_count", o_conv_count, 16'd2);
    i_stby_n = 1'b1;
    tick(1);

    // CS_N high masks RD_N.
    conv_meas(-1, len);
    chk("c_busy_len", len, 20);
    chk("c_count", o_conv_count, 16'd3);
    rd_chk("c_ch0", 16'd2);
    rd_chk("c_ch1", 16'd258);
    bif.cs_n = 1'b1;
    rd_word(d, oe);
    chk("csn_db_hold", d, 16'd258);
    chk("csn_oe", oe, 1'b0);
    bif.cs_n = 1'b0;
    tick(1);
    rd_chk("c_ch2", 16'd514);

    // Async reset mid-readout.
    i_rst_n = 1'b0;
    #1;
    chk("arst_busy", bif.busy, 1'b0);
    chk("arst_db", bif.db, 16'h0);
    chk("arst_db_oe", bif.db_oe, 1'b0);
    chk("arst_overrun", o_overrun, 1'b0);
    chk("arst_count", o_conv_count, 16'h0);
    tick(2);
    i_rst_n = 1'b1;
    tick(2);
    conv_meas(-1, len);
    chk("d_busy_len", len, 20);
    chk("d_count", o_conv_count, 16'd1);
    rd_chk("d_ch0", 16'd0);
    rd_chk("d_ch1", 16'd256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
